decode_queue: RTL and testbench

//   Parametrised instruction buffer and pre-decoder between fetch and decode.

---
 rtl/decode_queue.sv | 219 +++++++++++++++++++++
 tb/tb_decode_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// decode_queue: instruction buffer between fetch and decode, pre-decoding each word as it is written.
// Latency: a word pushed at edge N is at the head after edge N; head fields are combinational from storage.
// Backpressure: in_ready drops when DEPTH entries are held or flush is high; the head is held until out_ready.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   flush                 discard all entries and the delay-slot tracking at the next edge
//   in_valid/in_ready     fetch handshake carrying in_inst / in_pc
//   out_valid/out_ready   decode handshake; out_inst, out_pc, out_delay_slot,
//                         out_kind {cti,load,store,muldiv,cp0}, out_exc {reserved,syscall,break,eret}
//   count                 current occupancy, 0..DEPTH
module decode_queue #(
    parameter int DEPTH         = 4,
    parameter bit ENABLE_MULDIV = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [31:0]                    in_inst,
    input  logic [31:0]                    in_pc,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_inst,
    output logic [31:0]                    out_pc,
    output logic                           out_delay_slot,
    output logic [4:0]                     out_kind,
    output logic [3:0]                     out_exc,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // One stored entry; classification is done once on the write path so the
    // read path is a plain mux out of the array.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        delay_slot;
        logic [4:0]  kind;
        logic [3:0]  exc;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          wr_entry;
    entry_t          head_entry;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic            cti_pending;
    logic            push;
    logic            pop;

    // ------------------------------------------------------------------
    // Write-side pre-decode
    // ------------------------------------------------------------------
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] func;

    logic k_cti;
    logic k_load;
    logic k_store;
    logic k_muldiv;
    logic k_cp0;
    logic e_reserved;
    logic e_syscall;
    logic e_break;
    logic e_eret;

    assign opcode = in_inst[31:26];
    assign rs     = in_inst[25:21];
    assign rt     = in_inst[20:16];
    assign func   = in_inst[5:0];

    always_comb begin
        k_cti      = 1'b0;
        k_load     = 1'b0;
        k_store    = 1'b0;
        k_muldiv   = 1'b0;
        k_cp0      = 1'b0;
        e_reserved = 1'b0;
        e_syscall  = 1'b0;
        e_break    = 1'b0;
        e_eret     = 1'b0;

        case (opcode)
            // SPECIAL: everything is keyed on func
            6'h00: begin
                case (func)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2A, 6'h2B: begin
                        // shifts / ALU: plain kind, no exception
                    end
                    6'h08, 6'h09: k_cti     = 1'b1;   // jr, jalr
                    6'h0C:        e_syscall = 1'b1;
                    6'h0D:        e_break   = 1'b1;
                    6'h10, 6'h11, 6'h12, 6'h13,
                    6'h18, 6'h19, 6'h1A, 6'h1B: begin
                        // mfhi/mthi/mflo/mtlo, mult/multu/div/divu
                        if (ENABLE_MULDIV) begin
                            k_muldiv = 1'b1;
                        end else begin
                            e_reserved = 1'b1;
                        end
                    end
                    default:      e_reserved = 1'b1;
                endcase
            end
            // REGIMM: bltz, bgez, bltzal, bgezal only
            6'h01: begin
                if (rt == 5'h00 || rt == 5'h01 || rt == 5'h10 || rt == 5'h11) begin
                    k_cti = 1'b1;
                end else begin
                    e_reserved = 1'b1;
                end
            end
            6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07: k_cti = 1'b1;
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                // immediate ALU ops: plain kind
            end
            // COP0: eret is checked first because its rs (CO bit set) would
            // otherwise fall into the reserved rs range.
            6'h10: begin
                if (rs[4] && func == 6'h18) begin
                    k_cp0  = 1'b1;
                    e_eret = 1'b1;
                end else if (rs == 5'h00 || rs == 5'h04) begin
                    k_cp0 = 1'b1;
                end else begin
                    e_reserved = 1'b1;
                end
            end
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: k_load  = 1'b1;
            6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E:               k_store = 1'b1;
            default: e_reserved = 1'b1;
        endcase
    end

    // Each decode path above sets at most one kind bit and at most one
    // exception bit, and reserved paths never set a kind bit.
    always_comb begin
        wr_entry            = '0;
        wr_entry.pc         = in_pc;
        wr_entry.inst       = in_inst;
        wr_entry.delay_slot = cti_pending;
        wr_entry.kind       = {k_cti, k_load, k_store, k_muldiv, k_cp0};
        wr_entry.exc        = {e_reserved, e_syscall, e_break, e_eret};
    end

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign in_ready  = (count < FULL) & ~flush;
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // ------------------------------------------------------------------
    // Pointers, occupancy and delay-slot tracking
    // ------------------------------------------------------------------
    // DEPTH is a power of two, so the PW-bit pointers wrap on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            cti_pending <= 1'b0;
        end else if (flush) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            cti_pending <= 1'b0;
        end else begin
            if (push) begin
                tail        <= tail + 1'b1;
                // A CTI sitting in a delay slot still arms the next slot.
                cti_pending <= k_cti;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset: stale contents are never visible because
    // the head is masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= wr_entry;
        end
    end

    // ------------------------------------------------------------------
    // Head read path
    // ------------------------------------------------------------------
    always_comb begin
        head_entry = '0;
        if (out_valid) begin
            head_entry = mem[head];
        end
    end

    assign out_inst       = head_entry.inst;
    assign out_pc         = head_entry.pc;
    assign out_delay_slot = head_entry.delay_slot;
    assign out_kind       = head_entry.kind;
    assign out_exc        = head_entry.exc;

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_ready;

    logic        in_ready, out_valid, out_delay_slot;
    logic [31:0] out_inst, out_pc;
    logic [4:0]  out_kind;
    logic [3:0]  out_exc;
    logic [2:0]  count;

    logic        nm_in_ready, nm_out_valid, nm_out_delay_slot;
    logic [31:0] nm_out_inst, nm_out_pc;
    logic [4:0]  nm_out_kind;
    logic [3:0]  nm_out_exc;
    logic [2:0]  nm_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(4), .ENABLE_MULDIV(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_delay_slot(out_delay_slot), .out_kind(out_kind), .out_exc(out_exc), .count(count)
    );

    decode_queue #(.DEPTH(4), .ENABLE_MULDIV(1'b0)) dut_nm (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(nm_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(nm_out_valid), .out_ready(out_ready), .out_inst(nm_out_inst), .out_pc(nm_out_pc),
        .out_delay_slot(nm_out_delay_slot), .out_kind(nm_out_kind), .out_exc(nm_out_exc), .count(nm_count)
    );

    // Directed classification table: instruction, expected kind, exc, delay slot.
    localparam int NTBL = 18;
    logic [31:0] tbl_inst [NTBL] = '{
        32'hFC000000, 32'h0000003F, 32'h0000000C, 32'h0000000D, 32'h42000018,
        32'h8C430000, 32'hAC430000, 32'h40026000, 32'h04210003, 32'h04020000,
        32'h03E00008, 32'h00000000, 32'h0000000E, 32'h08000000, 32'h30A5FFFF,
        32'h40800000, 32'h40200000, 32'h42000001};
    logic [4:0] tbl_kind [NTBL] = '{
        5'h00, 5'h00, 5'h00, 5'h00, 5'h01,
        5'h08, 5'h04, 5'h01, 5'h10, 5'h00,
        5'h10, 5'h00, 5'h00, 5'h10, 5'h00,
        5'h01, 5'h00, 5'h00};
    logic [3:0] tbl_exc [NTBL] = '{
        4'h8, 4'h8, 4'h4, 4'h2, 4'h1,
        4'h0, 4'h0, 4'h0, 4'h0, 4'h8,
        4'h0, 4'h0, 4'h8, 4'h0, 4'h0,
        4'h0, 4'h8, 4'h8};
    logic tbl_ds [NTBL] = '{
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
        1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
        1'b0, 1'b0, 1'b0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = 32'h0; in_pc = 32'h0;
        #3;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_checks++; if ({out_inst, out_pc, out_delay_slot, out_kind, out_exc} !== 74'h0) begin
            n_fail++; $display("FAIL reset_outputs inst=%h pc=%h ds=%b kind=%b exc=%b exp all 0",
                               out_inst, out_pc, out_delay_slot, out_kind, out_exc); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_delay_slot();
        push_one(32'h10220003, 32'hBFC00000);
        push_one(32'h00851021, 32'hBFC00004);
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL ds_count got %0d exp 2", count); end
        n_checks++; if (out_pc !== 32'hBFC00000 || out_inst !== 32'h10220003) begin
            n_fail++; $display("FAIL ds_head0 pc=%h inst=%h exp bfc00000 10220003", out_pc, out_inst); end
        n_checks++; if (out_kind !== 5'b10000 || out_delay_slot !== 1'b0 || out_exc !== 4'h0) begin
            n_fail++; $display("FAIL ds_beq kind=%b ds=%b exc=%b exp 10000 0 0000", out_kind, out_delay_slot, out_exc); end
        pop_one();
        n_checks++; if (out_pc !== 32'hBFC00004) begin n_fail++; $display("FAIL ds_head1 pc=%h exp bfc00004", out_pc); end
        n_checks++; if (out_kind !== 5'b0 || out_delay_slot !== 1'b1 || out_exc !== 4'h0) begin
            n_fail++; $display("FAIL ds_addu kind=%b ds=%b exc=%b exp 00000 1 0000", out_kind, out_delay_slot, out_exc); end
        pop_one();
        n_checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin
            n_fail++; $display("FAIL ds_drain valid=%b count=%0d exp 0 0", out_valid, count); end
    endtask

    task automatic test_full_backpressure();
        for (int i = 0; i < 4; i++) push_one(32'h00851021, 32'h100 + 32'(i * 4));
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d exp 4", count); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
        // Fifth offered and held for two cycles while decode stalls.
        in_valid = 1'b1; in_inst = 32'h00851021; in_pc = 32'h110;
        tick(); tick();
        n_checks++; if (count !== 3'd4 || out_pc !== 32'h100) begin
            n_fail++; $display("FAIL full_hold count=%0d pc=%h exp 4 100", count, out_pc); end
        out_ready = 1'b1;
        tick();
        n_checks++; if (count !== 3'd3 || out_pc !== 32'h104 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL full_pop1 count=%0d pc=%h rdy=%b exp 3 104 1", count, out_pc, in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (count !== 3'd3 || out_pc !== 32'h108) begin
            n_fail++; $display("FAIL full_accept5 count=%0d pc=%h exp 3 108", count, out_pc); end
        tick();
        n_checks++; if (out_pc !== 32'h10C) begin n_fail++; $display("FAIL full_order3 pc=%h exp 10c", out_pc); end
        tick();
        n_checks++; if (out_pc !== 32'h110 || count !== 3'd1) begin
            n_fail++; $display("FAIL full_order4 pc=%h count=%0d exp 110 1", out_pc, count); end
        tick();
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin
            n_fail++; $display("FAIL full_drain valid=%b count=%0d exp 0 0", out_valid, count); end
    endtask

    task automatic test_classify();
        for (int i = 0; i < NTBL; i++) begin
            push_one(tbl_inst[i], 32'h400 + 32'(i * 4));
            n_checks++;
            if (out_valid !== 1'b1 || out_kind !== tbl_kind[i] || out_exc !== tbl_exc[i] ||
                out_delay_slot !== tbl_ds[i]) begin
                n_fail++;
                $display("FAIL classify[%0d] inst=%h valid=%b kind=%b exc=%b ds=%b exp 1 %b %b %b",
                         i, tbl_inst[i], out_valid, out_kind, out_exc, out_delay_slot,
                         tbl_kind[i], tbl_exc[i], tbl_ds[i]);
            end
            pop_one();
        end
    endtask

    task automatic test_flush();
        push_one(32'h0C000100, 32'h200);
        n_checks++; if (count !== 3'd1 || out_kind !== 5'b10000) begin
            n_fail++; $display("FAIL flush_jal count=%0d kind=%b exp 1 10000", count, out_kind); end
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00851021; in_pc = 32'h204;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_clear count=%0d valid=%b exp 0 0", count, out_valid); end
        push_one(32'h00851021, 32'h208);
        n_checks++; if (count !== 3'd1 || out_pc !== 32'h208 || out_delay_slot !== 1'b0) begin
            n_fail++; $display("FAIL flush_next count=%0d pc=%h ds=%b exp 1 208 0", count, out_pc, out_delay_slot); end
        pop_one();
    endtask

    task automatic test_muldiv();
        push_one(32'h00850018, 32'h500);
        n_checks++; if (out_kind !== 5'b00010 || out_exc !== 4'h0) begin
            n_fail++; $display("FAIL muldiv_on_mult kind=%b exc=%b exp 00010 0000", out_kind, out_exc); end
        n_checks++; if (nm_out_kind !== 5'b0 || nm_out_exc !== 4'b1000) begin
            n_fail++; $display("FAIL muldiv_off_mult kind=%b exc=%b exp 00000 1000", nm_out_kind, nm_out_exc); end
        pop_one();
        push_one(32'h00001010, 32'h504);
        n_checks++; if (out_kind !== 5'b00010 || nm_out_exc !== 4'b1000) begin
            n_fail++; $display("FAIL muldiv_mfhi kind=%b nm_exc=%b exp 00010 1000", out_kind, nm_out_exc); end
        pop_one();
    endtask

    task automatic test_back_to_back();
        push_one(32'h00851021, 32'h300);
        push_one(32'h00851021, 32'h304);
        for (int j = 1; j <= 10; j++) begin
            in_valid = 1'b1; in_inst = 32'h00851021; in_pc = 32'h300 + 32'((j + 1) * 4);
            out_ready = 1'b1;
            tick();
            n_checks++;
            if (out_pc !== 32'h300 + 32'(j * 4) || count !== 3'd2) begin
                n_fail++;
                $display("FAIL b2b[%0d] pc=%h count=%0d exp %h 2", j, out_pc, count, 32'h300 + 32'(j * 4));
            end
        end
        // Asynchronous reset mid-stream, away from any clock edge.
        reset = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || count !== 3'd0 || out_pc !== 32'h0) begin
            n_fail++; $display("FAIL b2b_reset valid=%b count=%0d pc=%h exp 0 0 0", out_valid, count, out_pc); end
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_after_reset rdy=%b valid=%b exp 1 0", in_ready, out_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_delay_slot();
        test_full_backpressure();
        test_classify();
        test_flush();
        test_muldiv();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
